// File: rtl/player_collision_detector.sv
// Per-frame player/obstacle collision detector with a valid/ack report to the movement controller.
// Optional macro PLAYER_COLLISION_OVERRUN_EN enables the sticky overrun flag and held-report protection.
module player_collision_detector #(
  parameter int NUM_OBSTACLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     playerDrawingRequest,
  input  logic [3:0]               HitEdgeCode,
  input  logic [NUM_OBSTACLES-1:0] obstacleDrawingRequest,
  input  logic                     collisionAck,
  output logic                     collisionValid,
  output logic [3:0]               collisionEdgeCode,
  output logic [NUM_OBSTACLES-1:0] collisionSource,
  output logic [CNT_WIDTH-1:0]     collisionFrames,
  output logic                     collisionOverrun
);

  typedef enum logic {
    IDLE   = 1'b0,
    REPORT = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic                     valid_q, valid_d;
  logic [3:0]               edge_out_q, edge_out_d;
  logic [NUM_OBSTACLES-1:0] src_out_q, src_out_d;
  logic [CNT_WIDTH-1:0]     frames_q, frames_d;

  logic [3:0]               edge_acc_q, edge_acc_d;
  logic [NUM_OBSTACLES-1:0] src_acc_q, src_acc_d;
  logic                     any_acc_q, any_acc_d;

  logic                     hit;
  logic [3:0]               hit_edge;
  logic [NUM_OBSTACLES-1:0] hit_src;
  logic                     new_report;

`ifdef PLAYER_COLLISION_OVERRUN_EN
  logic                     overrun_q, overrun_d;
`endif

  assign hit        = playerDrawingRequest & (|obstacleDrawingRequest);
  assign hit_edge   = hit ? HitEdgeCode : 4'h0;
  assign hit_src    = hit ? obstacleDrawingRequest : '0;
  assign new_report = startOfFrame & any_acc_q;

  // The startOfFrame pixel belongs to the new frame, so it seeds the accumulators.
  always_comb begin
    if (startOfFrame) begin
      edge_acc_d = hit_edge;
      src_acc_d  = hit_src;
      any_acc_d  = hit;
    end else begin
      edge_acc_d = edge_acc_q | hit_edge;
      src_acc_d  = src_acc_q | hit_src;
      any_acc_d  = any_acc_q | hit;
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    edge_out_d = edge_out_q;
    src_out_d  = src_out_q;
    frames_d   = frames_q;
`ifdef PLAYER_COLLISION_OVERRUN_EN
    overrun_d  = overrun_q;
`endif

    if (new_report && (frames_q != {CNT_WIDTH{1'b1}})) begin
      frames_d = frames_q + CNT_WIDTH'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (new_report) begin
          state_d    = REPORT;
          valid_d    = 1'b1;
          edge_out_d = edge_acc_q;
          src_out_d  = src_acc_q;
        end
      end
      REPORT: begin
        if (new_report) begin
          if (collisionAck) begin
            edge_out_d = edge_acc_q;
            src_out_d  = src_acc_q;
          end else begin
`ifdef PLAYER_COLLISION_OVERRUN_EN
            overrun_d  = 1'b1;
`else
            edge_out_d = edge_acc_q;
            src_out_d  = src_acc_q;
`endif
          end
        end else if (collisionAck) begin
          // Report data reads zero whenever nothing is pending.
          state_d    = IDLE;
          valid_d    = 1'b0;
          edge_out_d = 4'h0;
          src_out_d  = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        valid_d    = 1'b0;
        edge_out_d = 4'h0;
        src_out_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      edge_out_q <= 4'h0;
      src_out_q  <= '0;
      frames_q   <= '0;
      edge_acc_q <= 4'h0;
      src_acc_q  <= '0;
      any_acc_q  <= 1'b0;
`ifdef PLAYER_COLLISION_OVERRUN_EN
      overrun_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      edge_out_q <= edge_out_d;
      src_out_q  <= src_out_d;
      frames_q   <= frames_d;
      edge_acc_q <= edge_acc_d;
      src_acc_q  <= src_acc_d;
      any_acc_q  <= any_acc_d;
`ifdef PLAYER_COLLISION_OVERRUN_EN
      overrun_q  <= overrun_d;
`endif
    end
  end

  assign collisionValid    = valid_q;
  assign collisionEdgeCode = edge_out_q;
  assign collisionSource   = src_out_q;
  assign collisionFrames   = frames_q;
`ifdef PLAYER_COLLISION_OVERRUN_EN
  assign collisionOverrun  = overrun_q;
`else
  assign collisionOverrun  = 1'b0;
`endif

endmodule

// File: tb/tb_player_collision_detector.sv
// Scoreboard bench for player_collision_detector: directed frames push expected reports,
// a monitor pops and compares each report the DUT presents.
module tb_player_collision_detector;

   localparam int N   = 4;
   localparam int CNT = 8;

   logic           clock;
   logic           resetN;
   logic           startOfFrame;
   logic           playerDrawingRequest;
   logic [3:0]     HitEdgeCode;
   logic [N-1:0]   obstacleDrawingRequest;
   logic           collisionAck;
   logic           collisionValid;
   logic [3:0]     collisionEdgeCode;
   logic [N-1:0]   collisionSource;
   logic [CNT-1:0] collisionFrames;
   logic           collisionOverrun;

   int checkCount = 0;
   int passCount  = 0;

   logic [3:0]   expEdgeQ[$];
   logic [N-1:0] expSrcQ[$];

   logic prevValid;
   logic prevHandshake;

   player_collision_detector #(
      .NUM_OBSTACLES(N),
      .CNT_WIDTH(CNT)
   ) dut (
      .clk(clock),
      .resetN(resetN),
      .startOfFrame(startOfFrame),
      .playerDrawingRequest(playerDrawingRequest),
      .HitEdgeCode(HitEdgeCode),
      .obstacleDrawingRequest(obstacleDrawingRequest),
      .collisionAck(collisionAck),
      .collisionValid(collisionValid),
      .collisionEdgeCode(collisionEdgeCode),
      .collisionSource(collisionSource),
      .collisionFrames(collisionFrames),
      .collisionOverrun(collisionOverrun)
   );

   // Free-running pixel clock, 10 time-unit period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard time limit so a stuck run still ends with a report line
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", passCount, checkCount);
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: every check in the bench goes through here
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      else
         passCount++;
   endtask

   // Drive one pixel cycle; called at posedge+1 and returns at the next posedge+1
   task automatic applyStimulus(input logic sof, input logic pdr, input logic [3:0] hec,
                                input logic [N-1:0] obs, input logic ack);
      startOfFrame           = sof;
      playerDrawingRequest   = pdr;
      HitEdgeCode            = hec;
      obstacleDrawingRequest = obs;
      collisionAck           = ack;
      @(posedge clock);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 4'b0000, 1'b0);
   endtask

   // Hand-computed expected report for the next frame that ends with a collision
   task automatic pushExpected(input logic [3:0] e, input logic [N-1:0] s);
      expEdgeQ.push_back(e);
      expSrcQ.push_back(s);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".valid"},   32'(collisionValid),    32'd0);
      checkOutput({tag, ".edge"},    32'(collisionEdgeCode), 32'd0);
      checkOutput({tag, ".source"},  32'(collisionSource),   32'd0);
      checkOutput({tag, ".frames"},  32'(collisionFrames),   32'd0);
      checkOutput({tag, ".overrun"}, 32'(collisionOverrun),  32'd0);
   endtask

   // Monitor: a report is presented when valid rises, or stays high right after an accepted handshake
   always @(negedge clock) begin
      if (!resetN) begin
         prevValid     <= 1'b0;
         prevHandshake <= 1'b0;
      end else begin
         if (collisionValid && (!prevValid || prevHandshake)) begin
            if (expEdgeQ.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL report.unexpected: got edge 0x%0h source 0x%0h, expected no report at %0t",
                        collisionEdgeCode, collisionSource, $time);
            end else begin
               checkOutput("report.edge",   32'(collisionEdgeCode), 32'(expEdgeQ.pop_front()));
               checkOutput("report.source", 32'(collisionSource),   32'(expSrcQ.pop_front()));
            end
         end
         prevValid     <= collisionValid;
         prevHandshake <= collisionValid & collisionAck;
      end
   end

   // Directed frame sequence
   initial begin
      resetN                 = 1'b0;
      startOfFrame           = 1'b0;
      playerDrawingRequest   = 1'b0;
      HitEdgeCode            = 4'h0;
      obstacleDrawingRequest = '0;
      collisionAck           = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkAllZero("reset");
      resetN = 1'b1;
      idleCycles(2);

      $display("[TB] single hit");
      applyStimulus(1'b0, 1'b1, 4'h8, 4'b0010, 1'b0);
      idleCycles(2);
      pushExpected(4'h8, 4'b0010);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'b0000, 1'b0);
      checkOutput("single.valid",  32'(collisionValid),  32'd1);
      checkOutput("single.frames", 32'(collisionFrames), 32'd1);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'b0000, 1'b1);
      checkOutput("single.ackValid", 32'(collisionValid),    32'd0);
      checkOutput("single.ackEdge",  32'(collisionEdgeCode), 32'd0);
      checkOutput("single.ackSrc",   32'(collisionSource),   32'd0);

      $display("[TB] non-overlap");
      idleCycles(2);
      applyStimulus(1'b0, 1'b1, 4'hF, 4'b0000, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'hF, 4'b1111, 1'b0);
      idleCycles(2);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'b0000, 1'b0);
      checkOutput("nohit.valid",  32'(collisionValid),  32'd0);
      checkOutput("nohit.frames", 32'(collisionFrames), 32'd1);

      $display("[TB] accumulation");
      applyStimulus(1'b0, 1'b1, 4'h4, 4'b0001, 1'b0);
      idleCycles(1);
      applyStimulus(1'b0, 1'b1, 4'h1, 4'b1000, 1'b0);
      idleCycles(1);
      pushExpected(4'h5, 4'b1001);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'b0000, 1'b0);
      checkOutput("accum.frames", 32'(collisionFrames), 32'd2);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'b0000, 1'b1);
      checkOutput("accum.ackValid", 32'(collisionValid), 32'd0);

      $display("[TB] overrun");
      idleCycles(1);
      applyStimulus(1'b0, 1'b1, 4'h2, 4'b0100, 1'b0);
      idleCycles(2);
      pushExpected(4'h2, 4'b0100);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'h1, 4'b0001, 1'b0);
      idleCycles(1);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'b0000, 1'b0);
      checkOutput("overrun.valid",  32'(collisionValid),  32'd1);
      checkOutput("overrun.frames", 32'(collisionFrames), 32'd4);
`ifdef PLAYER_COLLISION_OVERRUN_EN
      checkOutput("overrun.edge",   32'(collisionEdgeCode), 32'h2);
      checkOutput("overrun.source", 32'(collisionSource),   32'h4);
      checkOutput("overrun.flag",   32'(collisionOverrun),  32'd1);
`else
      checkOutput("overrun.edge",   32'(collisionEdgeCode), 32'h1);
      checkOutput("overrun.source", 32'(collisionSource),   32'h1);
      checkOutput("overrun.flag",   32'(collisionOverrun),  32'd0);
`endif

      $display("[TB] ack with simultaneous new report");
      applyStimulus(1'b0, 1'b1, 4'h8, 4'b0011, 1'b0);
      idleCycles(1);
      pushExpected(4'h8, 4'b0011);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'b0000, 1'b1);
      checkOutput("ackload.valid",  32'(collisionValid),    32'd1);
      checkOutput("ackload.edge",   32'(collisionEdgeCode), 32'h8);
      checkOutput("ackload.source", 32'(collisionSource),   32'h3);
      checkOutput("ackload.frames", 32'(collisionFrames),   32'd5);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'b0000, 1'b1);
      checkOutput("ackload.ackValid", 32'(collisionValid), 32'd0);

      $display("[TB] hit on the startOfFrame pixel");
      applyStimulus(1'b0, 1'b1, 4'h2, 4'b0001, 1'b0);
      idleCycles(1);
      pushExpected(4'h2, 4'b0001);
      applyStimulus(1'b1, 1'b1, 4'h4, 4'b1000, 1'b0);
      checkOutput("boundary.edge", 32'(collisionEdgeCode), 32'h2);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'b0000, 1'b1);
      idleCycles(2);
      pushExpected(4'h4, 4'b1000);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'b0000, 1'b0);
      checkOutput("boundary.nextEdge", 32'(collisionEdgeCode), 32'h4);
      checkOutput("boundary.frames",   32'(collisionFrames),   32'd7);

      $display("[TB] counter saturation");
      for (int f = 0; f < 300; f++) begin
         pushExpected(4'h1, 4'b0001);
         applyStimulus(1'b0, 1'b1, 4'h1, 4'b0001, 1'b1);
         idleCycles(1);
         applyStimulus(1'b1, 1'b0, 4'h0, 4'b0000, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 4'b0000, 1'b1);
      checkOutput("saturate.frames", 32'(collisionFrames), 32'd255);
`ifdef PLAYER_COLLISION_OVERRUN_EN
      checkOutput("saturate.overrunSticky", 32'(collisionOverrun), 32'd1);
`endif

      $display("[TB] reset while a report is pending");
      idleCycles(1);
      applyStimulus(1'b0, 1'b1, 4'h8, 4'b0010, 1'b0);
      idleCycles(1);
      pushExpected(4'h8, 4'b0010);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'h1, 4'b0001, 1'b0);
      @(negedge clock);
      #1;
      resetN = 1'b0;
      #1;
      checkAllZero("asyncReset");
      @(posedge clock);
      #1;
      resetN = 1'b1;
      applyStimulus(1'b0, 1'b1, 4'h4, 4'b0100, 1'b0);
      idleCycles(1);
      pushExpected(4'h4, 4'b0100);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'b0000, 1'b0);
      checkOutput("postReset.frames", 32'(collisionFrames), 32'd1);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'b0000, 1'b1);
      idleCycles(3);

      checkOutput("scoreboard.pending", 32'(expEdgeQ.size()), 32'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/player_collision_detector.md
# player_collision_detector

Per-frame collision detector directly downstream of the player bitmap stage. Each pixel clock it checks whether the player's drawing request coincides with any obstacle's drawing request, and accumulates the player's 4-bit hit-edge code and the set of touched obstacles over the frame. At each frame boundary it presents one collision report to the movement controller over a valid/ack handshake, and counts collision frames.

## Interface
- NUM_OBSTACLES, 4, number of obstacle drawing-request inputs (1..16)
- CNT_WIDTH, 8, width of saturating collision-frame counter
- clk  input  1  pixel clock
- resetN  input  1  asynchronous active-low reset
- startOfFrame  input  1  one-cycle pulse marking the first pixel of a frame
- playerDrawingRequest  input  1  player bitmap drawing request (registered, pipeline-aligned)
- HitEdgeCode  input  4  player bitmap edge code {Left, Top, Right, Bottom}, aligned with playerDrawingRequest
- obstacleDrawingRequest  input  NUM_OBSTACLES  obstacle drawing requests, same pipeline alignment as player
- collisionAck  input  1  consumer accepts the current report
- collisionValid  output  1  report pending
- collisionEdgeCode  output  4  OR of HitEdgeCode over all colliding pixels of reported frame
- collisionSource  output  NUM_OBSTACLES  OR of obstacle requests over colliding pixels of reported frame
- collisionFrames  output  CNT_WIDTH  saturating count of frames containing at least one collision
- collisionOverrun  output  1  sticky: a report was lost because the previous one was unacknowledged

## Operation
- Hit in cycle t: hit = playerDrawingRequest & (|obstacleDrawingRequest).
- Accumulators edgeAcc[3:0], srcAcc[N-1:0], anyAcc: on hit, OR in HitEdgeCode, obstacleDrawingRequest, 1.
- On startOfFrame: the accumulators are reloaded with the current cycle's contribution only, which is 0 if there is no hit. The current pixel belongs to the new frame. The old accumulator values go to frame-end processing.
- Frame-end processing with old anyAcc=1:
  - collisionFrames increments, saturating at all-ones.
  - In IDLE: load collisionEdgeCode/collisionSource from the old accumulators and go to REPORT.
  - In REPORT with collisionAck=0: overrun. Held report is kept, new report discarded, collisionOverrun set.
  - In REPORT with collisionAck=1 in the same cycle: the new report is loaded and the FSM stays in REPORT.
- Frame-end with old anyAcc=0: no report. An ack in that cycle moves the FSM to IDLE normally.
- FSM:
  - IDLE (collisionValid=0) -> REPORT on frame-end with a collision.
  - REPORT (collisionValid=1) -> IDLE on collisionAck without a new report in the same cycle.
  - collisionAck in IDLE is ignored.
- collisionEdgeCode/collisionSource are stable while collisionValid=1 and read 0 in IDLE.
- collisionOverrun is cleared only by reset.

## Timing
- Reset value of every output: collisionValid=0, collisionEdgeCode=0, collisionSource=0, collisionFrames=0, collisionOverrun=0. Accumulators are 0 and the FSM is in IDLE.
- All outputs are registered. There is no combinational input-to-output path.
- A startOfFrame pulse at cycle t produces collisionValid=1 and the report data at t+1.
- Ack seen at cycle t drops collisionValid at t+1.
- A collision on the last pixel before startOfFrame (cycle t-1) is included in the report at t+1.
- A reset asserted mid-frame or mid-report clears everything immediately. After release, the first report covers only the pixels from that point on.
- Consumer must not assume more than one report per frame. The bench drives startOfFrame at least 3 cycles apart.

## Configuration
- PLAYER_COLLISION_OVERRUN_EN defined: overrun detection and the sticky collisionOverrun flag behave as above.
- Not defined:
  - collisionOverrun is tied to 0 and its flop is removed.
  - On an unacknowledged frame-end with a collision, the new report overwrites the held one. collisionValid stays 1.
  - collisionFrames behaves identically in both builds.

## Test plan
- Single hit:
  - Stimulus: player=1, HitEdgeCode=4'h8, obstacle=4'b0010 for 1 cycle mid-frame, then startOfFrame.
  - Required: next cycle valid=1, edge=8, source=2, frames=1. Ack gives valid=0 the following cycle.
- Non-overlap:
  - Stimulus: player and obstacle requests in different cycles across a whole frame.
  - Required: no report and frames unchanged.
- Accumulation:
  - Stimulus: hits with edge 4'h4/src 4'b0001, then edge 4'h1/src 4'b1000 in the same frame.
  - Required: report edge=4'h5, source=4'b1001.
- Overrun and ack collisions:
  - Stimulus: two collision frames, no ack.
  - Required with macro: first report held and overrun=1. Required without macro: second report shown and overrun=0.
  - Stimulus: ack on the same cycle as startOfFrame with a new collision.
  - Required: valid stays 1 and the new data is loaded.
- Boundary and reset:
  - Stimulus: hit in the startOfFrame cycle itself.
  - Required: it is excluded from the current report and appears in the next.
  - Stimulus: 300 collision frames with CNT_WIDTH=8.
  - Required: frames=255.
  - Stimulus: resetN pulse while valid=1.
  - Required: all outputs 0 asynchronously.
